// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed active-low 7-segment scanner with per-digit
// enable, decimal points, PWM brightness and frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 10_000,
  parameter int unsigned BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_done
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [VAL_W-1:0]    stg_val_q, stg_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   stg_en_q, stg_en_d, disp_en_q, disp_en_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                tick, last_slot, boundary, lit;
  logic [DIGITS-1:0]   lz_blank;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_en;

  // Segment pattern (g..a, active low) for one hex nibble
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Prescaler, digit index, PWM counter and double-buffer update
  always_comb begin
    tick      = (presc_q == PRE_W'(SCAN_DIV - 1));
    last_slot = (idx_q == IDX_W'(DIGITS - 1));
    boundary  = tick & last_slot;

    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (tick) idx_d = last_slot ? '0 : idx_q + IDX_W'(1);
    pwm_d   = pwm_q + BRIGHT_W'(1);

    stg_val_d = stg_val_q;
    stg_dp_d  = stg_dp_q;
    stg_en_d  = stg_en_q;
    if (load) begin
      stg_val_d = value;
      stg_dp_d  = dp_mask;
      stg_en_d  = digit_en;
    end

    // A load landing on the boundary bypasses staging so slot 0 shows it at once
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    disp_en_d  = disp_en_q;
    if (boundary) begin
      disp_val_d = stg_val_d;
      disp_dp_d  = stg_dp_d;
      disp_en_d  = stg_en_d;
    end
    frame_done_d = boundary;
  end

`ifdef SEG7_LZ_BLANK_EN
  logic supp;

  // Blank leading zero digits from the MSD down; dp or a non-zero nibble stops it
  always_comb begin
    lz_blank = '0;
    supp     = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (supp && (i != 0) && (disp_val_q[4*i +: 4] == 4'h0) && !disp_dp_q[i])
        lz_blank[i] = 1'b1;
      else
        supp = 1'b0;
    end
  end
`else
  // Leading-zero blanking disabled: every enabled digit is shown
  always_comb begin
    lz_blank = '0;
  end
`endif

  // Select the current digit and form the next anode/segment outputs
  always_comb begin
    lit     = (&brightness) | (pwm_q < brightness);
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    an_d    = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = disp_val_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
        cur_en  = disp_en_q[i] & ~lz_blank[i];
        an_d[i] = ~(lit & cur_en);
      end
    end
    seg_d = (&an_d) ? 8'hFF : {~cur_dp, hex_seg(cur_nib)};
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      stg_val_q    <= '0;
      stg_dp_q     <= '0;
      stg_en_q     <= '1;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_en_q    <= '1;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      stg_val_q    <= stg_val_d;
      stg_dp_q     <= stg_dp_d;
      stg_en_q     <= stg_en_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_en_q    <= disp_en_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SEG        = seg_q;
  assign AN         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver (4 digits, 4 clk slots, 2-bit PWM).
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned BRIGHT_W = 2;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [3:0] LZ30_EN = 4'b0011;
  localparam logic [3:0] LZ0_EN  = 4'b0001;
`else
  localparam logic [3:0] LZ30_EN = 4'b1111;
  localparam logic [3:0] LZ0_EN  = 4'b1111;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic [3:0]  digit_en;
  logic [1:0]  brightness;
  logic [7:0]  SEG;
  logic [3:0]  AN;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  int          pend_j = -1;
  logic [15:0] pend_val;
  logic [3:0]  pend_dp;
  logic [3:0]  pend_en;

  seg7_scan_driver #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .BRIGHT_W(BRIGHT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .dp_mask   (dp_mask),
    .digit_en  (digit_en),
    .brightness(brightness),
    .SEG       (SEG),
    .AN        (AN),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] hex_pat(input logic [3:0] n);
    case (n)
      4'h0: hex_pat = 8'hC0;  4'h1: hex_pat = 8'hF9;
      4'h2: hex_pat = 8'hA4;  4'h3: hex_pat = 8'hB0;
      4'h4: hex_pat = 8'h99;  4'h5: hex_pat = 8'h92;
      4'h6: hex_pat = 8'h82;  4'h7: hex_pat = 8'hF8;
      4'h8: hex_pat = 8'h80;  4'h9: hex_pat = 8'h90;
      4'hA: hex_pat = 8'h88;  4'hB: hex_pat = 8'h83;
      4'hC: hex_pat = 8'hC6;  4'hD: hex_pat = 8'hA1;
      4'hE: hex_pat = 8'h86;  default: hex_pat = 8'h8E;
    endcase
  endfunction

  // Check one 16-clk frame starting right after a frame_done sample; optionally
  // raise load for one clk after sample pend_j.
  task automatic check_frame(input string name, input logic [15:0] v, input logic [3:0] en,
                             input logic [3:0] dp, input logic [1:0] br);
    int         slot;
    int         p;
    logic       lit;
    logic [3:0] ean;
    logic [7:0] eseg;
    logic [7:0] h;
    for (int j = 0; j < 16; j++) begin
      slot = j / 4;
      p    = j % 4;
      lit  = (br == 2'd3) || (p < int'(br));
      ean  = 4'hF;
      if (lit && en[slot]) ean[slot] = 1'b0;
      h    = hex_pat(v[4*slot +: 4]);
      eseg = (ean == 4'hF) ? 8'hFF : {~dp[slot], h[6:0]};
      @(negedge clk);
      chk($sformatf("%s_an%0d", name, j), 32'(AN), 32'(ean));
      chk($sformatf("%s_seg%0d", name, j), 32'(SEG), 32'(eseg));
      chk($sformatf("%s_fd%0d", name, j), 32'(frame_done), 32'(j == 15));
      load = 1'b0;
      if (j == pend_j) begin
        value    = pend_val;
        dp_mask  = pend_dp;
        digit_en = pend_en;
        load     = 1'b1;
      end
    end
    pend_j = -1;
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    load       = 1'b0;
    value      = 16'h0000;
    dp_mask    = 4'h0;
    digit_en   = 4'hF;
    brightness = 2'd3;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_seg", 32'(SEG), 32'hFF);
    chk("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an", 32'(AN), 32'hE);
    chk("post_rst_seg", 32'(SEG), 32'hC0);

    // reset asserted mid-scan
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_an", 32'(AN), 32'hF);
    chk("mid_rst_seg", 32'(SEG), 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_an", 32'(AN), 32'hE);
    chk("restart_seg", 32'(SEG), 32'hC0);
    chk("restart_fd", 32'(frame_done), 32'h0);

    value = 16'h12AF;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;

    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sync_fd", 32'(frame_done), 32'h1);

    pend_j = 5;  pend_val = 16'h3456; pend_en = 4'hF; pend_dp = 4'h0;
    check_frame("f12af", 16'h12AF, 4'hF, 4'h0, 2'd3);
    pend_j = 14; pend_val = 16'h7890; pend_en = 4'hF; pend_dp = 4'h0;
    check_frame("f3456", 16'h3456, 4'hF, 4'h0, 2'd3);
    check_frame("bypass", 16'h7890, 4'hF, 4'h0, 2'd3);
    brightness = 2'd1;
    check_frame("bright1", 16'h7890, 4'hF, 4'h0, 2'd1);
    brightness = 2'd0;
    pend_j = 14; pend_val = 16'h12AF; pend_en = 4'b1010; pend_dp = 4'b0010;
    check_frame("bright0", 16'h7890, 4'hF, 4'h0, 2'd0);
    brightness = 2'd3;
    pend_j = 14; pend_val = 16'h0030; pend_en = 4'hF; pend_dp = 4'h0;
    check_frame("den", 16'h12AF, 4'b1010, 4'b0010, 2'd3);
    pend_j = 14; pend_val = 16'h0000; pend_en = 4'hF; pend_dp = 4'h0;
    check_frame("lz30", 16'h0030, LZ30_EN, 4'h0, 2'd3);
    check_frame("lz0", 16'h0000, LZ0_EN, 4'h0, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
